logica_juego: RTL

Tic-tac-toe game-state engine that sits directly upstream of the video generator in the VGA top level. It conditions the three raw push-buttons (move, place, new game), keeps the 3×3 board, cursor and turn, and detects a win or a draw. It drives the per-cell occupancy and result signals that the video generator renders and mirrors to the LEDs. It runs on the 25 MHz pixel clock.

---
 rtl/juego_pkg.sv | 52 +++++
 rtl/boton_antirrebote.sv | 48 ++++
 rtl/logica_juego.sv | 136 +++++++++++++
 3 files changed

// File: rtl/juego_pkg.sv
// Shared types, line masks and board helpers for the tic-tac-toe engine.
package juego_pkg;

    localparam int NUM_CELDAS = 9;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        GANA_NONE = 2'b00,
        GANA_X    = 2'b01,
        GANA_O    = 2'b10,
        GANA_DRAW = 2'b11
    } ganador_t;

    // Rows, columns, then the two diagonals; bit i is cell i in row-major order.
    localparam logic [8:0] LINEAS [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    function automatic logic hay_linea(input logic [8:0] marcas);
        hay_linea = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((marcas & LINEAS[k]) == LINEAS[k]) begin
                hay_linea = 1'b1;
            end
        end
    endfunction

    // Next empty cell after pos (wrapping), or pos itself when no other cell is free.
    function automatic logic [3:0] siguiente_libre(input logic [3:0] pos,
                                                   input logic [8:0] ocupado);
        logic [3:0] p;
        logic       hallado;
        siguiente_libre = pos;
        p               = pos;
        hallado         = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p = (p == 4'd8) ? 4'd0 : p + 4'd1;
            if (!hallado && !ocupado[p]) begin
                siguiente_libre = p;
                hallado         = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/boton_antirrebote.sv
// Push-button conditioning: 2-flop synchronizer, level debounce, rising-edge pulse.
module boton_antirrebote #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic boton,
    output logic pulso
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             estable_r;
    logic             estable_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pulso_r;

    // Synchronize, debounce against the accepted level and register the edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            estable_r   <= 1'b0;
            estable_d_r <= 1'b0;
            cnt_r       <= '0;
            pulso_r     <= 1'b0;
        end else begin
            sync1_r     <= boton;
            sync2_r     <= sync1_r;
            estable_d_r <= estable_r;
            pulso_r     <= estable_r & ~estable_d_r;
            if (sync2_r == estable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_ULTIMO) begin
                estable_r <= sync2_r;
                cnt_r     <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign pulso = pulso_r;

endmodule

// File: rtl/logica_juego.sv
// Tic-tac-toe game-state engine: buttons, board, cursor, turn and result.
// Optional macro CURSOR_SKIP_EN: cursor skips occupied cells and auto-advances after a place.
module logica_juego
    import juego_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boton,
    input  logic       boton2,
    input  logic       boton3,
    output logic [8:0] cell_x,
    output logic [8:0] cell_o,
    output logic [3:0] cursor,
    output logic       turn,
    output logic [1:0] winner,
    output logic       game_over
);

    logic p_move_s, p_place_s, p_new_s;

    boton_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_move (
        .clk(clk), .rst(rst), .boton(boton), .pulso(p_move_s));
    boton_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_place (
        .clk(clk), .rst(rst), .boton(boton2), .pulso(p_place_s));
    boton_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_new (
        .clk(clk), .rst(rst), .boton(boton3), .pulso(p_new_s));

    estado_t    estado_r, estado_nx;
    logic [8:0] cell_x_r, cell_x_nx, cell_o_r, cell_o_nx;
    logic [3:0] cursor_r, cursor_nx;
    logic       turn_r, turn_nx;
    logic [1:0] winner_r, winner_nx;
    logic       game_over_r;
    logic [8:0] ocupado_s, marca_s, jugador_s;

    // Next-state logic; p_new overrides everything, place wins over move.
    always_comb begin
        estado_nx = estado_r;
        cell_x_nx = cell_x_r;
        cell_o_nx = cell_o_r;
        cursor_nx = cursor_r;
        turn_nx   = turn_r;
        winner_nx = winner_r;
        ocupado_s = cell_x_r | cell_o_r;
        marca_s   = 9'd1 << cursor_r;
        jugador_s = turn_r ? cell_o_r : cell_x_r;
        if (p_new_s) begin
            estado_nx = PLAY;
            cell_x_nx = 9'd0;
            cell_o_nx = 9'd0;
            cursor_nx = 4'd0;
            turn_nx   = 1'b0;
            winner_nx = GANA_NONE;
        end else begin
            case (estado_r)
                PLAY: begin
                    if (p_place_s) begin
                        if ((ocupado_s & marca_s) == 9'd0) begin
                            if (turn_r) begin
                                cell_o_nx = cell_o_r | marca_s;
                            end else begin
                                cell_x_nx = cell_x_r | marca_s;
                            end
                            estado_nx = CHECK;
`ifdef CURSOR_SKIP_EN
                            cursor_nx = siguiente_libre(cursor_r, ocupado_s | marca_s);
`else
                            cursor_nx = cursor_r;
`endif
                        end else begin
                            estado_nx = PLAY;
                        end
                    end else if (p_move_s) begin
`ifdef CURSOR_SKIP_EN
                        cursor_nx = siguiente_libre(cursor_r, ocupado_s);
`else
                        cursor_nx = (cursor_r == 4'd8) ? 4'd0 : cursor_r + 4'd1;
`endif
                    end else begin
                        estado_nx = PLAY;
                    end
                end
                CHECK: begin
                    // turn_r still names the player who just placed
                    if (hay_linea(jugador_s)) begin
                        winner_nx = turn_r ? GANA_O : GANA_X;
                        estado_nx = OVER;
                    end else if (ocupado_s == 9'h1FF) begin
                        winner_nx = GANA_DRAW;
                        estado_nx = OVER;
                    end else begin
                        turn_nx   = ~turn_r;
                        estado_nx = PLAY;
                    end
                end
                OVER: begin
                    estado_nx = OVER;
                end
                default: begin
                    estado_nx = PLAY;
                end
            endcase
        end
    end

    // Game state registers; all outputs come straight from these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r    <= PLAY;
            cell_x_r    <= 9'd0;
            cell_o_r    <= 9'd0;
            cursor_r    <= 4'd0;
            turn_r      <= 1'b0;
            winner_r    <= GANA_NONE;
            game_over_r <= 1'b0;
        end else begin
            estado_r    <= estado_nx;
            cell_x_r    <= cell_x_nx;
            cell_o_r    <= cell_o_nx;
            cursor_r    <= cursor_nx;
            turn_r      <= turn_nx;
            winner_r    <= winner_nx;
            game_over_r <= (estado_nx == OVER);
        end
    end

    assign cell_x    = cell_x_r;
    assign cell_o    = cell_o_r;
    assign cursor    = cursor_r;
    assign turn      = turn_r;
    assign winner    = winner_r;
    assign game_over = game_over_r;

endmodule
